// File: rtl/bsearch_probe_ctrl.sv
// Successive-approximation search controller: issues probes to a magnitude
// comparator and narrows [lo,hi] by binary search until the comparator reports equal.
module bsearch_probe_ctrl #(
  parameter int unsigned W  = 5,
  parameter int unsigned SW = $clog2(W + 2)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          lesser,
  input  logic          greater,
  input  logic          equal,
  output logic [W-1:0]  probe,
  output logic          probe_valid,
  output logic          done,
  output logic [W-1:0]  found,
  output logic [SW-1:0] steps,
  output logic          error
);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE, ERR} state_t;

  localparam logic [W-1:0] MAX_VAL = '1;
  localparam logic [W-1:0] FIRST   = MAX_VAL >> 1;

  state_t        state, state_d;
  logic [W-1:0]  lo, hi, lo_d, hi_d;
  logic [W-1:0]  probe_d, found_d;
  logic [SW-1:0] steps_d;
  logic          done_d, error_d;
  logic          adv;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      lo    <= '0;
      hi    <= MAX_VAL;
      probe <= '0;
      steps <= '0;
      done  <= 1'b0;
      found <= '0;
      error <= 1'b0;
    end else begin
      state <= state_d;
      lo    <= lo_d;
      hi    <= hi_d;
      probe <= probe_d;
      steps <= steps_d;
      done  <= done_d;
      found <= found_d;
      error <= error_d;
    end
  end

  // Next-state and range narrowing
  always_comb begin
    state_d = state;
    lo_d    = lo;
    hi_d    = hi;
    probe_d = probe;
    steps_d = steps;
    done_d  = done;
    found_d = found;
    error_d = error;
    adv     = 1'b0;

    case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = SEARCH;
          lo_d    = '0;
          hi_d    = MAX_VAL;
          probe_d = FIRST;
          steps_d = SW'(1);
          done_d  = 1'b0;
          error_d = 1'b0;
          found_d = '0;
        end
      end
      SEARCH: begin
        case ({lesser, greater, equal})
          3'b001: begin
            found_d = probe;
            done_d  = 1'b1;
            state_d = DONE;
          end
          3'b100: begin
            if (probe < hi) begin
              lo_d = probe + W'(1);
              adv  = 1'b1;
            end else begin
              error_d = 1'b1;
              state_d = ERR;
            end
          end
          3'b010: begin
            if (probe > lo) begin
              hi_d = probe - W'(1);
              adv  = 1'b1;
            end else begin
              error_d = 1'b1;
              state_d = ERR;
            end
          end
          default: begin
            error_d = 1'b1;
            state_d = ERR;
          end
        endcase
      end
      default: state_d = IDLE;
    endcase

    // lo_d <= hi_d whenever adv is set, so the midpoint never overflows W bits
    if (adv) begin
      probe_d = lo_d + ((hi_d - lo_d) >> 1);
      steps_d = steps + SW'(1);
    end
  end

  assign probe_valid = (state == SEARCH);

endmodule
